// File: rtl/axis_flit_serializer.sv
// axis_flit_serializer: splits wide AXI-Stream beats into SERIALIZATION_FACTOR
// flits (LSB slice first) and injects them into a credit-flow-controlled
// ring router input port.
// Ports:
//   clk, rst                      NoC clock, synchronous active-high reset
//   axis_tvalid/tready/tdata/     upstream AXI-Stream beat interface
//   tlast/tdest
//   data_out, dest_out,           registered flit payload, destination, tail flag
//   is_tail_out, send_out         send_out pulses once per issued flit
//   credit_in                     one downstream buffer slot freed (pulse)
//   credit_error                  sticky: credit returned with counter already full
module axis_flit_serializer #(
  parameter int unsigned TDATA_WIDTH          = 512,
  parameter int unsigned SERIALIZATION_FACTOR = 4,
  parameter int unsigned DEST_WIDTH           = 6,
  parameter int unsigned FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         axis_tvalid,
  output logic                                         axis_tready,
  input  logic [TDATA_WIDTH-1:0]                       axis_tdata,
  input  logic                                         axis_tlast,
  input  logic [DEST_WIDTH-1:0]                        axis_tdest,
  output logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]                        dest_out,
  output logic                                         is_tail_out,
  output logic                                         send_out,
  input  logic                                         credit_in,
  output logic                                         credit_error
);

  localparam int unsigned FLIT_WIDTH   = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int unsigned CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int unsigned IDX_WIDTH    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_WIDTH-1:0]    LAST_IDX    = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
  localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  // Parameter legality checks at elaboration
  if (SERIALIZATION_FACTOR < 1) begin : g_bad_sf
    $error("SERIALIZATION_FACTOR must be >= 1");
  end else if ((TDATA_WIDTH % SERIALIZATION_FACTOR) != 0) begin : g_bad_div
    $error("TDATA_WIDTH must be divisible by SERIALIZATION_FACTOR");
  end
  if (FLIT_BUFFER_DEPTH < 1) begin : g_bad_depth
    $error("FLIT_BUFFER_DEPTH must be >= 1");
  end

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t                    state, state_next;
  logic [IDX_WIDTH-1:0]      idx, idx_next;
  logic [CREDIT_WIDTH-1:0]   credits;
  logic [TDATA_WIDTH-1:0]    hold_data;
  logic                      hold_last;
  logic [DEST_WIDTH-1:0]     hold_dest;
  logic [FLIT_WIDTH-1:0]     flit_c;
  logic                      send_c;
  logic                      accept_c;

  // Ready when idle, or when the last flit of the held beat leaves this edge
  assign axis_tready = !rst && ((state == EMPTY) ||
                                ((state == HOLD) && (idx == LAST_IDX) && (credits != '0)));
  assign accept_c    = axis_tvalid && axis_tready;
  // Registered credit count gates the send; a same-edge credit_in cannot help
  assign send_c      = (state == HOLD) && (credits != '0);

  // Select the current flit slice of the held beat
  always_comb begin
    flit_c = '0;
    for (int unsigned i = 0; i < SERIALIZATION_FACTOR; i++) begin
      if (idx == IDX_WIDTH'(i)) flit_c = hold_data[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  // Next-state and flit index
  always_comb begin
    state_next = state;
    idx_next   = idx;
    unique case (state)
      EMPTY: begin
        if (accept_c) begin
          state_next = HOLD;
          idx_next   = '0;
        end
      end
      HOLD: begin
        if (send_c) begin
          if (idx == LAST_IDX) begin
            state_next = accept_c ? HOLD : EMPTY;
            idx_next   = '0;
          end else begin
            idx_next = idx + IDX_WIDTH'(1);
          end
        end
      end
      default: begin
        state_next = EMPTY;
        idx_next   = '0;
      end
    endcase
  end

  // State, credits and registered flit outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      idx          <= '0;
      credits      <= MAX_CREDITS;
      send_out     <= 1'b0;
      data_out     <= '0;
      dest_out     <= '0;
      is_tail_out  <= 1'b0;
      credit_error <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      send_out <= send_c;
      if (send_c) begin
        data_out    <= flit_c;
        dest_out    <= hold_dest;
        is_tail_out <= hold_last && (idx == LAST_IDX);
      end
      if (send_c && !credit_in) begin
        credits <= credits - CREDIT_WIDTH'(1);
      end else if (!send_c && credit_in) begin
        if (credits == MAX_CREDITS) credit_error <= 1'b1;
        else                        credits      <= credits + CREDIT_WIDTH'(1);
      end
    end
  end

  // Beat hold register; only meaningful while in HOLD so it needs no reset
  always_ff @(posedge clk) begin
    if (accept_c) begin
      hold_data <= axis_tdata;
      hold_last <= axis_tlast;
      hold_dest <= axis_tdest;
    end
  end

endmodule

// File: tb/tb_axis_flit_serializer.sv
// tb_axis_flit_serializer: directed and randomized stimulus for
// axis_flit_serializer, checked each cycle against a flit-queue/credit model.
module tb_axis_flit_serializer;

  localparam int unsigned TW    = 512;
  localparam int unsigned SF    = 4;
  localparam int unsigned DW    = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = TW / SF;

  logic          clk = 1'b0;
  logic          rst;
  logic          axis_tvalid;
  logic          axis_tready;
  logic [TW-1:0] axis_tdata;
  logic          axis_tlast;
  logic [DW-1:0] axis_tdest;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic          credit_error;

  axis_flit_serializer #(
    .TDATA_WIDTH(TW), .SERIALIZATION_FACTOR(SF), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
    .axis_tlast(axis_tlast), .axis_tdest(axis_tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_error(credit_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] d;
    logic [DW-1:0] dest;
    logic          tail;
  } flit_t;

  // Reference model: pending flits of the held beat, downstream credit pool
  flit_t         q[$];
  int            credits;
  bit            err_m;
  bit            m_send;
  logic [FW-1:0] m_data;
  logic [DW-1:0] m_dest;
  logic          m_tail;
  int            ret_q[$];
  bit            ret_en;
  int            ret_delay;
  int            cyc;
  int            n_sent;
  int            errors;
  int            checks;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [TW-1:0] rnd_beat();
    logic [TW-1:0] r;
    for (int i = 0; i < int'(TW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Flit k is a byte fill of value k
  function automatic logic [TW-1:0] pat_beat();
    logic [TW-1:0] r;
    for (int k = 0; k < int'(SF); k++)
      for (int b = 0; b < int'(FW / 8); b++) r[k*FW + b*8 +: 8] = 8'(k);
    return r;
  endfunction

  // One clock cycle: drive at negedge, check ready, advance model at posedge, check outputs
  task automatic step(input logic v, input logic [TW-1:0] d, input logic l, input logic [DW-1:0] dst,
                      input logic r, input logic crf, output bit acc);
    bit    cr, due, tr_exp, snd;
    flit_t f;
    due = (ret_q.size() > 0) && (ret_q[0] <= cyc);
    if (due) void'(ret_q.pop_front());
    cr = due || crf;
    rst = r; axis_tvalid = v; axis_tdata = d; axis_tlast = l; axis_tdest = dst; credit_in = cr;
    #1;
    tr_exp = !r && ((q.size() == 0) || ((q.size() == 1) && (credits > 0)));
    chk("tready", FW'(axis_tready), FW'(tr_exp));
    acc = v && tr_exp;
    @(posedge clk);
    if (r) begin
      q.delete(); ret_q.delete();
      credits = DEPTH; err_m = 0; m_send = 0; m_data = '0; m_dest = '0; m_tail = 1'b0;
    end else begin
      snd = (q.size() > 0) && (credits > 0);
      m_send = snd;
      if (snd) begin
        f = q.pop_front();
        m_data = f.d; m_dest = f.dest; m_tail = f.tail;
        if (ret_en) ret_q.push_back(cyc + ret_delay);
      end
      if (snd && !cr) credits--;
      else if (!snd && cr) begin
        if (credits == DEPTH) err_m = 1;
        else credits++;
      end
      if (acc) begin
        for (int k = 0; k < int'(SF); k++) begin
          f.d = d[k*FW +: FW]; f.dest = dst; f.tail = l && (k == int'(SF) - 1);
          q.push_back(f);
        end
      end
    end
    cyc++;
    @(negedge clk);
    if (send_out === 1'b1) n_sent++;
    chk("send_out", FW'(send_out), FW'(m_send));
    chk("data_out", data_out, m_data);
    chk("dest_out", FW'(dest_out), FW'(m_dest));
    chk("is_tail_out", FW'(is_tail_out), FW'(m_tail));
    chk("credit_error", FW'(credit_error), FW'(err_m));
  endtask

  task automatic idle(input int n, input logic r);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b1, rnd_beat(), 1'b1, DW'(i), r, 1'b0, acc);
  endtask

  task automatic run_beats(input int nbeats, input int ncyc, input bit pat, input bit rnd_v,
                           input bit rnd_l, input logic [DW-1:0] dst_fixed, input bit rnd_dst);
    int            bi;
    bit            v, acc;
    logic [TW-1:0] d;
    logic          l;
    logic [DW-1:0] dst;
    bi = 0;
    d = pat ? pat_beat() : rnd_beat();
    l = rnd_l ? 1'($urandom_range(0, 1)) : (nbeats == 1);
    dst = rnd_dst ? DW'($urandom) : dst_fixed;
    for (int c = 0; c < ncyc; c++) begin
      v = (bi < nbeats) && (!rnd_v || ($urandom_range(0, 3) != 0));
      step(v, d, l, dst, 1'b0, 1'b0, acc);
      if (acc) begin
        bi++;
        d = pat ? pat_beat() : rnd_beat();
        l = rnd_l ? 1'($urandom_range(0, 1)) : (bi == nbeats - 1);
        dst = rnd_dst ? DW'($urandom) : dst_fixed;
      end
    end
  endtask

  initial begin
    int base;
    bit acc;
    errors = 0; checks = 0; cyc = 0; n_sent = 0;
    ret_en = 1'b1; ret_delay = 2;
    credits = DEPTH; err_m = 0; m_send = 0; m_data = '0; m_dest = '0; m_tail = 1'b0;
    rst = 1'b1; axis_tvalid = 1'b0; axis_tdata = '0; axis_tlast = 1'b0; axis_tdest = '0; credit_in = 1'b0;
    @(negedge clk);

    // Reset held with tvalid high; ready in first cycle after release
    idle(3, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, acc);

    // Single patterned beat, credits returned 2 cycles after each send
    base = n_sent;
    run_beats(1, 12, 1'b1, 1'b0, 1'b0, DW'(6'h15), 1'b0);
    chk("single_beat_flits", FW'(n_sent - base), FW'(4));

    // Credit starvation: no returns, then one credit pulse releases one flit
    idle(1, 1'b1);
    ret_en = 1'b0;
    base = n_sent;
    run_beats(3, 14, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("starve_flits", FW'(n_sent - base), FW'(4));
    base = n_sent;
    step(1'b1, rnd_beat(), 1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 5; i++) step(1'b1, rnd_beat(), 1'b0, '0, 1'b0, 1'b0, acc);
    chk("starve_one_credit", FW'(n_sent - base), FW'(1));

    // Streaming with immediate credit return: 32 flits back to back
    idle(1, 1'b1);
    ret_en = 1'b1; ret_delay = 1;
    base = n_sent;
    run_beats(8, 34, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("stream_flits", FW'(n_sent - base), FW'(32));

    // Return delay 3 keeps credits at 1 with send+credit on the same edge
    idle(1, 1'b1);
    ret_delay = 3;
    base = n_sent;
    run_beats(4, 18, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("credit1_flits", FW'(n_sent - base), FW'(16));
    // Return delay 4 drains credits; same-edge credit must not enable a send
    ret_delay = 4;
    run_beats(3, 30, 1'b0, 1'b0, 1'b1, '0, 1'b1);

    // Spurious credit at full count sets sticky error, cleared by reset
    idle(1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, acc);
    ret_delay = 2;
    run_beats(2, 14, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, acc);

    // Reset after the first flit drops the rest of the beat
    step(1'b1, pat_beat(), 1'b1, DW'(6'h2a), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, acc);
    idle(1, 1'b1);
    base = n_sent;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, acc);
    chk("midbeat_drop", FW'(n_sent - base), FW'(0));
    run_beats(1, 8, 1'b1, 1'b0, 1'b0, DW'(6'h07), 1'b0);

    // Randomized traffic with varying credit return latency
    for (int r = 0; r < 8; r++) begin
      idle(1, 1'b1);
      ret_delay = int'($urandom_range(1, 6));
      run_beats(10, 70, 1'b0, 1'b1, 1'b1, '0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
